// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter for the single 8-bit main-memory port,
// shared by the CPU core (port C) and the debug/loader master (port D).
// Every transaction takes three cycles: IDLE (grant) -> ACCESS (strobe) ->
// DONE (ack, read capture). All outputs are registered.
//
// Ports:
//   clk, rstn              clock; synchronous reset, active-high (1 = reset)
//   c_req/c_we/c_addr/c_wdata   CPU request, held until c_ack
//   c_ack, c_rdata              CPU completion pulse and read data
//   d_req/d_we/d_addr/d_wdata   loader request, held until d_ack
//   d_ack, d_rdata              loader completion pulse and read data
//   mem_a, mem_wd               RAM address and write data
//   mem_oe                      data-bus drive enable (high with mem_we)
//   mem_we, mem_re              RAM write/read strobes
//   mem_q                       RAM read data, valid the cycle after mem_re
//   busy                        high whenever not in IDLE
//   owner                       current or last grant (0 = C, 1 = D)
module mem_arbiter #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  output logic          mem_oe,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_q,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state;
  logic   lat_we;

  logic          grant_d_c;
  logic          sel_we_c;
  logic [AW-1:0] sel_addr_c;
  logic [DW-1:0] sel_wdata_c;

  // Winner selection: a lone requester wins; on a tie the non-owner wins.
  always_comb begin
    grant_d_c = d_req;
    if (c_req && d_req) begin
      grant_d_c = ~owner;
    end
    sel_we_c    = grant_d_c ? d_we    : c_we;
    sel_addr_c  = grant_d_c ? d_addr  : c_addr;
    sel_wdata_c = grant_d_c ? d_wdata : c_wdata;
  end

  // FSM with registered strobes, acks and read-data capture.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state   <= IDLE;
      lat_we  <= 1'b0;
      mem_a   <= '0;
      mem_wd  <= '0;
      mem_oe  <= 1'b0;
      mem_we  <= 1'b0;
      mem_re  <= 1'b0;
      c_ack   <= 1'b0;
      d_ack   <= 1'b0;
      c_rdata <= '0;
      d_rdata <= '0;
      busy    <= 1'b0;
      owner   <= 1'b1;   // CPU wins the first tie
    end else begin
      case (state)
        IDLE: begin
          if (c_req || d_req) begin
            state  <= ACCESS;
            busy   <= 1'b1;
            owner  <= grant_d_c;
            lat_we <= sel_we_c;
            mem_a  <= sel_addr_c;
            mem_wd <= sel_wdata_c;
            mem_we <= sel_we_c;
            mem_oe <= sel_we_c;
            mem_re <= ~sel_we_c;
          end
        end
        ACCESS: begin
          state  <= DONE;
          mem_we <= 1'b0;
          mem_oe <= 1'b0;
          mem_re <= 1'b0;
          c_ack  <= ~owner;
          d_ack  <= owner;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          c_ack <= 1'b0;
          d_ack <= 1'b0;
          // mem_q is valid now, one cycle after the read strobe
          if (!lat_we) begin
            if (owner) begin
              d_rdata <= mem_q;
            end else begin
              c_rdata <= mem_q;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference model (grant schedule, memory image, rdata).
module tb_mem_arbiter;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          c_req, c_we, d_req, d_we;
  logic [AW-1:0] c_addr, d_addr;
  logic [DW-1:0] c_wdata, d_wdata;
  logic          c_ack, d_ack;
  logic [DW-1:0] c_rdata, d_rdata;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic          mem_oe, mem_we, mem_re;
  logic [DW-1:0] mem_q;
  logic          busy, owner;

  // RAM environment with a preload side-port
  logic [DW-1:0] ram [256];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  // reference memory image
  logic [DW-1:0] ref_mem [256];

  int tests_run;
  int tests_failed;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rstn(rstn),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_oe(mem_oe), .mem_we(mem_we),
    .mem_re(mem_re), .mem_q(mem_q), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (mem_we) ram[mem_a] <= mem_wd;
    if (mem_re) mem_q <= ram[mem_a];
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    ref_mem[a] = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic do_reset();
    c_req = 1'b0;
    d_req = 1'b0;
    rstn  = 1'b1;
    tick();
    tick();
    rstn  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({c_ack, d_ack, mem_re, mem_we, mem_oe, busy, owner} !== 7'b0000001) begin
      tests_failed++;
      $display("FAIL reset_flags got=%b exp=0000001",
               {c_ack, d_ack, mem_re, mem_we, mem_oe, busy, owner});
    end
    tests_run++;
    if ({c_rdata, d_rdata, mem_a, mem_wd} !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_data got=%h exp=00000000", {c_rdata, d_rdata, mem_a, mem_wd});
    end
  endtask

  task automatic test_single_read();
    do_reset();
    preload(8'h3A, 8'h5C);
    c_req = 1'b1; c_we = 1'b0; c_addr = 8'h3A; c_wdata = 8'h00;
    tick();
    tests_run++;
    if ({mem_re, mem_we, mem_oe, mem_a} !== {3'b100, 8'h3A}) begin
      tests_failed++;
      $display("FAIL read_access got=%b_%h exp=100_3a", {mem_re, mem_we, mem_oe}, mem_a);
    end
    tick();
    tests_run++;
    if ({c_ack, d_ack} !== 2'b10) begin
      tests_failed++;
      $display("FAIL read_ack got=%b exp=10", {c_ack, d_ack});
    end
    c_req = 1'b0;
    tick();
    tests_run++;
    if ({c_ack, busy, c_rdata} !== {2'b00, 8'h5C}) begin
      tests_failed++;
      $display("FAIL read_data got=%b_%h exp=00_5c", {c_ack, busy}, c_rdata);
    end
  endtask

  task automatic test_single_write();
    logic ok;
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h10; d_wdata = 8'hA5;
    tick();
    tests_run++;
    if ({mem_we, mem_oe, mem_re, mem_wd, mem_a} !== {3'b110, 8'hA5, 8'h10}) begin
      tests_failed++;
      $display("FAIL write_access got=%b_%h_%h exp=110_a5_10",
               {mem_we, mem_oe, mem_re}, mem_wd, mem_a);
    end
    tick();
    tests_run++;
    if ({c_ack, d_ack} !== 2'b01) begin
      tests_failed++;
      $display("FAIL write_ack got=%b exp=01", {c_ack, d_ack});
    end
    d_req = 1'b0;
    tick();
    // CPU read-back of the written location
    ok = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 8'h10;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (c_ack) begin
        ok = 1'b1;
        break;
      end
    end
    c_req = 1'b0;
    tick();
    tests_run++;
    if (!ok || c_rdata !== 8'hA5 || d_rdata !== 8'h00) begin
      tests_failed++;
      $display("FAIL write_readback ack=%b c_rdata=%h d_rdata=%h exp=1 a5 00",
               ok, c_rdata, d_rdata);
    end
  endtask

  task automatic test_simultaneous();
    int         n;
    int         cc;
    int         dc;
    int         exp_cyc [4];
    logic [3:0] exp_port;
    exp_cyc  = '{2, 5, 8, 11};
    exp_port = 4'b1010;   // C, D, C, D (bit 0 first)
    n = 0; cc = 0; dc = 0;
    do_reset();
    c_we = 1'b0; d_we = 1'b0; c_addr = 8'h01; d_addr = 8'h02;
    c_req = 1'b1; d_req = 1'b1;
    for (int k = 1; k < 15; k++) begin
      tick();
      if (c_ack || d_ack) begin
        tests_run++;
        if (n >= 4 || (c_ack && d_ack) || k != exp_cyc[n] ||
            d_ack !== exp_port[n] || owner !== exp_port[n]) begin
          tests_failed++;
          $display("FAIL rr_grant idx=%0d cyc=%0d c_ack=%b d_ack=%b owner=%b exp_cyc=%0d",
                   n, k, c_ack, d_ack, owner, (n < 4) ? exp_cyc[n] : -1);
        end
        n++;
      end
      if (c_ack) begin c_req = 1'b0; cc++; end
      else if (!c_req && cc < 2) c_req = 1'b1;
      if (d_ack) begin d_req = 1'b0; dc++; end
      else if (!d_req && dc < 2) d_req = 1'b1;
    end
    tests_run++;
    if (n != 4) begin
      tests_failed++;
      $display("FAIL rr_count got=%0d exp=4", n);
    end
  endtask

  task automatic test_field_change();
    do_reset();
    preload(8'h20, 8'h77);
    preload(8'h21, 8'h99);
    c_req = 1'b1; c_we = 1'b0; c_addr = 8'h20;
    tick();
    c_addr = 8'h21;
    tests_run++;
    if ({mem_re, mem_a} !== {1'b1, 8'h20}) begin
      tests_failed++;
      $display("FAIL fc_access got=%b_%h exp=1_20", mem_re, mem_a);
    end
    tick();
    tests_run++;
    if ({c_ack, mem_a} !== {1'b1, 8'h20}) begin
      tests_failed++;
      $display("FAIL fc_done got=%b_%h exp=1_20", c_ack, mem_a);
    end
    tick();
    tests_run++;
    if ({busy, c_rdata} !== {1'b0, 8'h77}) begin
      tests_failed++;
      $display("FAIL fc_idle got=%b_%h exp=0_77", busy, c_rdata);
    end
    tick();
    c_req = 1'b0;
    tests_run++;
    if ({mem_re, mem_a} !== {1'b1, 8'h21}) begin
      tests_failed++;
      $display("FAIL fc_second got=%b_%h exp=1_21", mem_re, mem_a);
    end
    tick();
    tick();
    tests_run++;
    if ({c_ack, busy, c_rdata} !== {2'b00, 8'h99}) begin
      tests_failed++;
      $display("FAIL fc_data got=%b_%h exp=00_99", {c_ack, busy}, c_rdata);
    end
  endtask

  task automatic test_reset_mid();
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h30; d_wdata = 8'hC3;
    tick();
    tests_run++;
    if ({mem_we, mem_oe} !== 2'b11) begin
      tests_failed++;
      $display("FAIL rm_access got=%b exp=11", {mem_we, mem_oe});
    end
    rstn = 1'b1;
    d_req = 1'b0;
    tick();
    tests_run++;
    if ({mem_we, mem_oe, mem_re, busy, c_ack, d_ack, owner} !== 7'b0000001 ||
        {c_rdata, d_rdata} !== 16'h0) begin
      tests_failed++;
      $display("FAIL rm_abort flags=%b rdata=%h exp=0000001 0000",
               {mem_we, mem_oe, mem_re, busy, c_ack, d_ack, owner}, {c_rdata, d_rdata});
    end
    rstn = 1'b0;
    tick();
    tests_run++;
    if ({busy, c_ack, d_ack} !== 3'b000) begin
      tests_failed++;
      $display("FAIL rm_noack got=%b exp=000", {busy, c_ack, d_ack});
    end
  endtask

  task automatic test_back_to_back();
    int acks;
    int ack_cyc [2];
    do_reset();
    preload(8'h00, 8'h11);
    preload(8'h01, 8'h22);
    acks = 0;
    ack_cyc = '{0, 0};
    c_req = 1'b1; c_we = 1'b0; c_addr = 8'h00; d_req = 1'b0;
    for (int k = 1; k < 9; k++) begin
      tick();
      if (c_ack) begin
        if (acks < 2) ack_cyc[acks] = k;
        acks++;
        if (acks == 1) c_addr = 8'h01;
        else c_req = 1'b0;
      end
      if (k == 3) begin
        tests_run++;
        if (c_rdata !== 8'h11) begin
          tests_failed++;
          $display("FAIL b2b_first got=%h exp=11", c_rdata);
        end
      end
      if (k == 6) begin
        tests_run++;
        if (c_rdata !== 8'h22) begin
          tests_failed++;
          $display("FAIL b2b_second got=%h exp=22", c_rdata);
        end
      end
    end
    tests_run++;
    if (acks != 2 || ack_cyc[0] != 2 || ack_cyc[1] != 5 || d_rdata !== 8'h00) begin
      tests_failed++;
      $display("FAIL b2b_timing acks=%0d cyc=%0d,%0d d_rdata=%h exp=2 2,5 00",
               acks, ack_cyc[0], ack_cyc[1], d_rdata);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_c_rd, exp_d_rd, t_wdata, t_rdata;
    logic [AW-1:0] t_addr;
    logic          t_port, t_we, m_owner, has_txn, in_acc, in_done;
    logic [6:0]    exp_flags;
    int            g, c_gap, d_gap;
    for (int a = 0; a < 256; a++) preload(AW'(a), DW'($urandom));
    do_reset();
    exp_c_rd = '0; exp_d_rd = '0; t_wdata = '0; t_rdata = '0; t_addr = '0;
    t_port = 1'b0; t_we = 1'b0; m_owner = 1'b1; has_txn = 1'b0;
    g = 0; c_gap = 0; d_gap = 0;
    for (int k = 0; k < 3000; k++) begin
      if (k > 0) tick();
      // transaction retires three cycles after its grant
      if (has_txn && k == g + 3) begin
        if (!t_we) begin
          if (t_port) exp_d_rd = t_rdata;
          else exp_c_rd = t_rdata;
        end
        has_txn = 1'b0;
      end
      in_acc  = has_txn && (k == g + 1);
      in_done = has_txn && (k == g + 2);
      exp_flags = {in_done && !t_port, in_done && t_port, in_acc && !t_we,
                   in_acc && t_we, in_acc && t_we, in_acc || in_done, m_owner};
      tests_run++;
      if ({c_ack, d_ack, mem_re, mem_we, mem_oe, busy, owner} !== exp_flags) begin
        tests_failed++;
        $display("FAIL rand_flags cyc=%0d got=%b exp=%b", k,
                 {c_ack, d_ack, mem_re, mem_we, mem_oe, busy, owner}, exp_flags);
      end
      tests_run++;
      if ({c_rdata, d_rdata} !== {exp_c_rd, exp_d_rd}) begin
        tests_failed++;
        $display("FAIL rand_rdata cyc=%0d got=%h_%h exp=%h_%h", k,
                 c_rdata, d_rdata, exp_c_rd, exp_d_rd);
      end
      if (in_acc || in_done) begin
        tests_run++;
        if (mem_a !== t_addr || (in_acc && t_we && mem_wd !== t_wdata)) begin
          tests_failed++;
          $display("FAIL rand_bus cyc=%0d mem_a=%h mem_wd=%h exp=%h %h", k,
                   mem_a, mem_wd, t_addr, t_wdata);
        end
      end
      // requesters: drop on ack, idle a random gap, jiggle fields while waiting
      if (c_ack) begin
        c_req = 1'b0; c_gap = $urandom_range(0, 3);
      end else if (!c_req) begin
        if (c_gap == 0) begin
          c_req = 1'b1; c_we = 1'($urandom_range(0, 1));
          c_addr = AW'($urandom_range(0, 15)); c_wdata = DW'($urandom);
        end else c_gap--;
      end else if ($urandom_range(0, 3) == 0) begin
        c_we = 1'($urandom_range(0, 1));
        c_addr = AW'($urandom_range(0, 15)); c_wdata = DW'($urandom);
      end
      if (d_ack) begin
        d_req = 1'b0; d_gap = $urandom_range(0, 5);
      end else if (!d_req) begin
        if (d_gap == 0) begin
          d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
          d_addr = AW'($urandom_range(0, 15)); d_wdata = DW'($urandom);
        end else d_gap--;
      end else if ($urandom_range(0, 3) == 0) begin
        d_we = 1'($urandom_range(0, 1));
        d_addr = AW'($urandom_range(0, 15)); d_wdata = DW'($urandom);
      end
      // model grant: requests sampled only while no transaction is in flight
      if (!has_txn && (c_req || d_req)) begin
        t_port  = (c_req && d_req) ? ~m_owner : d_req;
        t_we    = t_port ? d_we : c_we;
        t_addr  = t_port ? d_addr : c_addr;
        t_wdata = t_port ? d_wdata : c_wdata;
        t_rdata = ref_mem[t_addr];
        if (t_we) ref_mem[t_addr] = t_wdata;
        m_owner = t_port;
        has_txn = 1'b1;
        g = k;
      end
    end
    c_req = 1'b0;
    d_req = 1'b0;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rstn = 1'b1;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    test_reset();
    test_single_read();
    test_single_write();
    test_simultaneous();
    test_field_change();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
